target_spawn_scheduler: RTL



---
 rtl/game_spawn_pkg.sv | 14 +
 rtl/spawn_lfsr16.sv | 17 +
 rtl/target_spawn_scheduler.sv | 83 ++++++++
 3 files changed

// File: rtl/game_spawn_pkg.sv
// game_spawn_pkg: shared types, LFSR taps and sizing helpers for the target spawn scheduler.
package game_spawn_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ON_SCREEN} spawn_state_t;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic int cnt_width(int min_delay, int delay_bits);
    return $clog2(min_delay + (1 << delay_bits));
  endfunction
  // Low delay_bits of the LFSR rotated right by sh; masked so callers may truncate freely.
  function automatic logic [7:0] rnd_slice(logic [15:0] x, int sh, int delay_bits);
    logic [15:0] r;
    r = (x >> sh) | (x << (16 - sh));
    return r[7:0] & 8'((1 << delay_bits) - 1);
  endfunction
endpackage

// File: rtl/spawn_lfsr16.sv
// spawn_lfsr16: free-running 16-bit Galois LFSR (right shift) with a configurable seed.
module spawn_lfsr16
  import game_spawn_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr
);
  logic [15:0] lfsr_d, lfsr_q;
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  assign lfsr = lfsr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= SEED;
    else lfsr_q <= lfsr_d;
endmodule

// File: rtl/target_spawn_scheduler.sv
// target_spawn_scheduler: launches targets after pseudo-random delays, one activation pulse per cycle.
`ifndef N_TARGETS
`define N_TARGETS 2
`endif
module target_spawn_scheduler
  import game_spawn_pkg::*;
#(
  parameter int          N_TARGETS  = `N_TARGETS,
  parameter int          MIN_DELAY  = 4,
  parameter int          DELAY_BITS = 6,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          SETTLE     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 round_start,
  input  logic                 round_active,
  input  logic [N_TARGETS-1:0] sprite_target_within_screen,
  output logic [N_TARGETS-1:0] new_target_activation,
  output logic [N_TARGETS-1:0] target_active
);
  localparam int CW = cnt_width(MIN_DELAY, DELAY_BITS);
  localparam int SW = SETTLE > 0 ? $clog2(SETTLE + 1) : 1;
  logic [15:0]          lfsr;
  logic [N_TARGETS-1:0] req, grant, nta_q, act_d, act_q;
  spawn_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst_n(rst_n), .lfsr(lfsr));
  // Lowest-index request wins; losers keep requesting until served.
  assign grant = req & (~req + N_TARGETS'(1));
  for (genvar g = 0; g < N_TARGETS; g++) begin : g_t
    spawn_state_t   st_d, st_q;
    logic [CW-1:0]  cnt_d, cnt_q, dly;
    logic [SW-1:0]  stl_d, stl_q;
    assign dly = CW'(MIN_DELAY) + CW'(rnd_slice(lfsr, (3 * g) % 16, DELAY_BITS));
    assign req[g] = st_q == WAIT && cnt_q == '0 && round_active && !round_start;
    assign act_d[g] = st_d == ON_SCREEN;
    always_comb begin
      st_d = st_q;
      cnt_d = cnt_q;
      stl_d = stl_q;
      if (!round_active) begin
        st_d = IDLE;
        cnt_d = '0;
        stl_d = '0;
      end else if (round_start) begin
        st_d = WAIT;
        cnt_d = dly;
        stl_d = '0;
      end else if (st_q == WAIT) begin
        if (grant[g]) begin
          st_d = ON_SCREEN;
          stl_d = SW'(SETTLE);
        end else if (tick && cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end else if (st_q == ON_SCREEN) begin
        if (stl_q != '0) stl_d = stl_q - 1'b1;
        else if (!sprite_target_within_screen[g]) begin
          st_d = WAIT;
          cnt_d = dly;
        end
      end
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        st_q <= IDLE;
        cnt_q <= '0;
        stl_q <= '0;
      end else begin
        st_q <= st_d;
        cnt_q <= cnt_d;
        stl_q <= stl_d;
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      nta_q <= '0;
      act_q <= '0;
    end else begin
      nta_q <= grant;
      act_q <= act_d;
    end
  assign new_target_activation = nta_q;
  assign target_active = act_q;
endmodule
